// File: rtl/image_stream_src.sv
// image_stream_src: frame-RAM pixel reader with a per-frame point op,
// emitting a framed ready/valid stream through a 2-entry FIFO.
// Ports: HCLK/HRESETn; start/mode/value/threshold control;
// mem_rd/mem_addr/mem_rdata RAM side; out_valid/out_ready/out_data
// with sof/eol/eof; VSYNC/HSYNC/busy/ctrl_done status.
module image_stream_src #(
  parameter int WIDTH          = 100,
  parameter int HEIGHT         = 100,
  parameter int PPC            = 2,
  parameter int START_UP_DELAY = 100,
  parameter int HSYNC_DELAY    = 160,
  parameter int FLIP_V         = 1,
  parameter int ADDR_W         = 16
) (
  input  logic                HCLK,
  input  logic                HRESETn,
  input  logic                start,
  input  logic [2:0]          mode,
  input  logic [7:0]          value,
  input  logic [7:0]          threshold,
  output logic                mem_rd,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic [24*PPC-1:0]   mem_rdata,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [24*PPC-1:0]   out_data,
  output logic                sof,
  output logic                eol,
  output logic                eof,
  output logic                VSYNC,
  output logic                HSYNC,
  output logic                busy,
  output logic                ctrl_done
);

  localparam int N    = WIDTH / PPC;
  localparam int DW   = 24 * PPC;
  localparam int FW   = DW + 3;
  localparam int CMAX = (START_UP_DELAY > HSYNC_DELAY) ?
                        START_UP_DELAY : HSYNC_DELAY;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int XW   = $clog2(N + 1);
  localparam int YW   = $clog2(HEIGHT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_VSYNC, S_HBLANK, S_DATA, S_LEND, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [2:0]    mode_q, mode_d;
  logic [7:0]    val_q, val_d;
  logic [7:0]    thr_q, thr_d;

  logic          rd_q;
  logic [2:0]    tag_q;
  logic [FW-1:0] fifo_q [2];
  logic          wp_q, rp_q;
  logic [1:0]    fcnt_q;

  logic          pop, push;
  logic [FW-1:0] head;
  logic [DW-1:0] proc;
  logic [2:0]    tag;
  logic [YW-1:0] row;
  logic [ADDR_W-1:0] addr;

  function automatic logic [23:0] pix_op(
    input logic [23:0] p,
    input logic [2:0]  m,
    input logic [7:0]  v,
    input logic [7:0]  t
  );
    logic [23:0] o;
    logic [9:0]  s;
    logic [8:0]  a;
    logic [7:0]  c;
    logic [7:0]  g;
    s = {2'b0, p[23:16]} + {2'b0, p[15:8]} + {2'b0, p[7:0]};
    g = 8'(s / 10'd3);
    o = p;
    for (int k = 0; k < 3; k++) begin
      c = p[8*k +: 8];
      a = {1'b0, c} + {1'b0, v};
      unique case (1'b1)
        m == 3'd1: o[8*k +: 8] = a[8] ? 8'hFF : a[7:0];
        m == 3'd2: o[8*k +: 8] = (c > v) ? c - v : 8'h00;
        m == 3'd3: o[8*k +: 8] = 8'hFF - g;
        m == 3'd4: o[8*k +: 8] = (g > t) ? 8'hFF : 8'h00;
        default:   o[8*k +: 8] = c;
      endcase
    end
    return o;
  endfunction

  assign head      = fifo_q[rp_q];
  assign out_valid = (fcnt_q != 2'd0);
  assign pop       = out_valid & out_ready;
  assign push      = rd_q;
  assign out_data  = out_valid ? head[DW-1:0] : '0;
  assign sof       = out_valid & head[DW+2];
  assign eol       = out_valid & head[DW+1];
  assign eof       = out_valid & head[DW];
  assign HSYNC     = out_valid;
  assign VSYNC     = (state_q == S_VSYNC);
  assign busy      = (state_q != S_IDLE);
  assign ctrl_done = (state_q == S_DONE);

  // Slot accounting covers both queued beats and the read still in the RAM.
  assign mem_rd = (state_q == S_DATA) &&
                  ((({1'b0, fcnt_q} + {2'b0, rd_q}) < 3'd2) || pop);

  assign row  = (FLIP_V != 0) ? YW'(HEIGHT - 1) - y_q : y_q;
  assign addr = ADDR_W'(row) * ADDR_W'(N) + ADDR_W'(x_q);
  assign mem_addr = mem_rd ? addr : '0;

  assign tag = {(x_q == '0) && (y_q == '0),
                x_q == XW'(N - 1),
                (x_q == XW'(N - 1)) && (y_q == YW'(HEIGHT - 1))};

  always_comb begin
    proc = '0;
    for (int k = 0; k < PPC; k++)
      proc[24*k +: 24] = pix_op(mem_rdata[24*k +: 24],
                                mode_q, val_q, thr_q);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    mode_d  = mode_q;
    val_d   = val_q;
    thr_d   = thr_q;
    unique case (state_q)
      S_IDLE: if (start) begin
        state_d = S_VSYNC;
        cnt_d   = '0;
        mode_d  = mode;
        val_d   = value;
        thr_d   = threshold;
      end
      S_VSYNC: if (cnt_q == CW'(START_UP_DELAY - 1)) begin
        state_d = S_HBLANK;
        cnt_d   = '0;
      end else cnt_d = cnt_q + CW'(1);
      S_HBLANK: if (cnt_q == CW'(HSYNC_DELAY - 1)) begin
        state_d = S_DATA;
        cnt_d   = '0;
      end else cnt_d = cnt_q + CW'(1);
      S_DATA: if (mem_rd) begin
        if (x_q == XW'(N - 1)) begin
          x_d     = '0;
          state_d = S_LEND;
        end else x_d = x_q + XW'(1);
      end
      S_LEND: if (fcnt_q == 2'd0 && !rd_q) begin
        if (y_q == YW'(HEIGHT - 1)) begin
          y_d     = '0;
          state_d = S_DONE;
        end else begin
          y_d     = y_q + YW'(1);
          state_d = S_HBLANK;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      mode_q  <= '0;
      val_q   <= '0;
      thr_q   <= '0;
      rd_q    <= 1'b0;
      tag_q   <= '0;
      wp_q    <= 1'b0;
      rp_q    <= 1'b0;
      fcnt_q  <= '0;
      for (int i = 0; i < 2; i++) fifo_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      mode_q  <= mode_d;
      val_q   <= val_d;
      thr_q   <= thr_d;
      rd_q    <= mem_rd;
      tag_q   <= tag;
      if (push) fifo_q[wp_q] <= {tag_q, proc};
      wp_q   <= wp_q ^ push;
      rp_q   <= rp_q ^ pop;
      fcnt_q <= fcnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_image_stream_src.sv
// tb_image_stream_src: randomized self-checking bench for
// image_stream_src against a frame-level reference model.
module tb_image_stream_src;

  localparam int W   = 4;
  localparam int H   = 2;
  localparam int P   = 2;
  localparam int SUD = 3;
  localparam int HSD = 4;
  localparam int FV  = 1;
  localparam int AW  = 8;
  localparam int N   = W / P;
  localparam int DW  = 24 * P;
  localparam int NW  = W * H / P;
  localparam int FRAME_CYC = 1 + SUD + H * (HSD + N + 3);

  logic          HCLK = 0;
  logic          HRESETn = 0;
  logic          start = 0;
  logic [2:0]    mode = 0;
  logic [7:0]    value = 0;
  logic [7:0]    threshold = 0;
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata = '0;
  logic          out_valid;
  logic          out_ready = 1;
  logic [DW-1:0] out_data;
  logic          sof, eol, eof;
  logic          VSYNC, HSYNC, busy, ctrl_done;

  image_stream_src #(
    .WIDTH(W), .HEIGHT(H), .PPC(P),
    .START_UP_DELAY(SUD), .HSYNC_DELAY(HSD),
    .FLIP_V(FV), .ADDR_W(AW)
  ) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .start(start),
    .mode(mode), .value(value), .threshold(threshold),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .sof(sof), .eol(eol), .eof(eof),
    .VSYNC(VSYNC), .HSYNC(HSYNC), .busy(busy),
    .ctrl_done(ctrl_done)
  );

  always #5 HCLK = ~HCLK;

  logic [DW-1:0] ram [NW];

  always @(posedge HCLK)
    if (mem_rd) mem_rdata <= ram[mem_addr[1:0]];

  int n_chk = 0;
  int n_fail = 0;

  logic [DW+2:0] got_q [$];
  logic [DW+2:0] exp_q [$];
  logic [DW+2:0] ref_q [$];
  int done_cnt, viol_stall, viol_out, addr_bad, rd_n, acc_n;
  logic prev_stall;
  logic [DW+2:0] prev_beat;

  always @(negedge HCLK) begin
    if (!HRESETn) begin
      prev_stall = 0;
      rd_n = 0;
      acc_n = 0;
    end else begin
      if (prev_stall &&
          (!out_valid || {sof, eol, eof, out_data} !== prev_beat))
        viol_stall++;
      if (out_valid && out_ready) begin
        got_q.push_back({sof, eol, eof, out_data});
        acc_n++;
      end
      if (mem_rd) begin
        rd_n++;
        if (mem_addr >= AW'(NW)) addr_bad++;
      end
      if (rd_n - acc_n > 2) viol_out++;
      if (ctrl_done) done_cnt++;
      prev_stall = out_valid && !out_ready;
      prev_beat  = {sof, eol, eof, out_data};
    end
  end

  function automatic logic [23:0] ref_pix(
    input logic [23:0] p, input int m, input int v, input int t);
    int ch [3];
    int grey;
    ch[0] = int'(p[23:16]);
    ch[1] = int'(p[15:8]);
    ch[2] = int'(p[7:0]);
    grey = (ch[0] + ch[1] + ch[2]) / 3;
    for (int i = 0; i < 3; i++) begin
      case (m)
        1: ch[i] = (ch[i] + v > 255) ? 255 : ch[i] + v;
        2: ch[i] = (ch[i] - v < 0) ? 0 : ch[i] - v;
        3: ch[i] = 255 - grey;
        4: ch[i] = (grey > t) ? 255 : 0;
        default: ;
      endcase
    end
    return {8'(ch[0]), 8'(ch[1]), 8'(ch[2])};
  endfunction

  task automatic build_exp(input int m, input int v, input int t);
    logic [DW-1:0] w, d;
    int row;
    exp_q.delete();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < N; c++) begin
        row = (FV != 0) ? H - 1 - r : r;
        w = ram[row * N + c];
        for (int k = 0; k < P; k++)
          d[24*k +: 24] = ref_pix(w[24*k +: 24], m, v, t);
        exp_q.push_back({r == 0 && c == 0, c == N - 1,
                         c == N - 1 && r == H - 1, d});
      end
  endtask

  task automatic clear_mon();
    got_q.delete();
    done_cnt = 0;
    viol_stall = 0;
    viol_out = 0;
    addr_bad = 0;
  endtask

  task automatic run_frame(
    input int m, input int v, input int t, input int pct,
    input bit poke, output int done_at, output int frd,
    output int fov, output logic [1:0] st1);
    done_at = -1;
    frd = -1;
    fov = -1;
    st1 = 2'b00;
    clear_mon();
    @(posedge HCLK); #1;
    start = 1;
    mode = 3'(m);
    value = 8'(v);
    threshold = 8'(t);
    @(posedge HCLK); #1;
    start = 0;
    mode = 3'($urandom);
    value = 8'($urandom);
    threshold = 8'($urandom);
    for (int idx = 1; idx < 2000; idx++) begin
      out_ready = (pct == 0) ? 1'b1 : ($urandom_range(99) >= pct);
      start = poke && (idx == 12);
      @(negedge HCLK);
      if (idx == 1) st1 = {busy, VSYNC};
      if (mem_rd && frd < 0) frd = idx;
      if (out_valid && fov < 0) fov = idx;
      if (ctrl_done) begin
        done_at = idx;
        break;
      end
      @(posedge HCLK); #1;
    end
    start = 0;
    @(posedge HCLK); #1;
    out_ready = 1;
  endtask

  task automatic test_reset();
    HRESETn = 0;
    #12;
    n_chk++;
    if ({mem_rd, mem_addr} !== '0) begin
      n_fail++;
      $display("FAIL reset_mem got %h want 0", {mem_rd, mem_addr});
    end
    n_chk++;
    if ({out_valid, out_data} !== '0) begin
      n_fail++;
      $display("FAIL reset_out got %h want 0", {out_valid, out_data});
    end
    n_chk++;
    if ({sof, eol, eof, VSYNC, HSYNC, busy, ctrl_done} !== 7'd0) begin
      n_fail++;
      $display("FAIL reset_flags got %b want 0",
               {sof, eol, eof, VSYNC, HSYNC, busy, ctrl_done});
    end
    @(posedge HCLK); #1;
    HRESETn = 1;
  endtask

  task automatic test_order();
    int d, f, o;
    logic [1:0] s1;
    int order [4];
    logic [2:0] fl [4];
    order = '{2, 3, 0, 1};
    fl = '{3'b100, 3'b010, 3'b000, 3'b011};
    for (int i = 0; i < NW; i++) ram[i] = {16'($urandom), $urandom};
    run_frame(0, 0, 0, 0, 0, d, f, o, s1);
    n_chk++;
    if (s1 !== 2'b11) begin
      n_fail++;
      $display("FAIL order_busy_vsync got %b want 11", s1);
    end
    n_chk++;
    if (f !== SUD + HSD + 1) begin
      n_fail++;
      $display("FAIL order_first_rd got %0d want %0d", f, SUD + HSD + 1);
    end
    n_chk++;
    if (o !== SUD + HSD + 3) begin
      n_fail++;
      $display("FAIL order_first_valid got %0d want %0d", o, SUD + HSD + 3);
    end
    n_chk++;
    if (d !== FRAME_CYC) begin
      n_fail++;
      $display("FAIL order_frame_cycles got %0d want %0d", d, FRAME_CYC);
    end
    n_chk++;
    if (got_q.size() != 4) begin
      n_fail++;
      $display("FAIL order_beats got %0d want 4", got_q.size());
    end
    for (int j = 0; j < got_q.size() && j < 4; j++) begin
      n_chk++;
      if (got_q[j] !== {fl[j], ram[order[j]]}) begin
        n_fail++;
        $display("FAIL order_beat%0d got %h want %h", j, got_q[j],
                 {fl[j], ram[order[j]]});
      end
    end
    n_chk++;
    if (done_cnt !== 1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL order_done got cnt=%0d busy=%b want 1/0",
               done_cnt, busy);
    end
  endtask

  task automatic test_ops();
    int d, f, o;
    logic [1:0] s1;
    logic [23:0] pix [5];
    int md [5];
    int vl [5];
    int th [5];
    logic [23:0] want [5];
    pix  = '{24'hC8329B, 24'hC8329B, 24'h0A141F, 24'h0A141F, 24'h0A141F};
    md   = '{1, 2, 3, 4, 4};
    vl   = '{100, 100, 0, 0, 0};
    th   = '{0, 0, 0, 20, 19};
    want = '{24'hFF96FF, 24'h640037, 24'hEBEBEB, 24'h000000, 24'hFFFFFF};
    for (int i = 0; i < 5; i++) begin
      for (int w = 0; w < NW; w++) ram[w] = {pix[i], pix[i]};
      run_frame(md[i], vl[i], th[i], 0, 0, d, f, o, s1);
      build_exp(md[i], vl[i], th[i]);
      n_chk++;
      if (got_q.size() != exp_q.size()) begin
        n_fail++;
        $display("FAIL ops%0d_beats got %0d want %0d", i,
                 got_q.size(), exp_q.size());
      end
      for (int j = 0; j < got_q.size() && j < exp_q.size(); j++) begin
        n_chk++;
        if (got_q[j][DW-1:0] !== {want[i], want[i]} ||
            got_q[j] !== exp_q[j]) begin
          n_fail++;
          $display("FAIL ops%0d_beat%0d got %h want %h", i, j,
                   got_q[j], exp_q[j]);
        end
      end
    end
  endtask

  task automatic test_stall();
    int d, f, o, m, v, t;
    logic [1:0] s1;
    for (int it = 0; it < 4; it++) begin
      for (int i = 0; i < NW; i++) ram[i] = {16'($urandom), $urandom};
      m = int'($urandom_range(7));
      v = int'($urandom_range(255));
      t = int'($urandom_range(255));
      run_frame(m, v, t, 0, 0, d, f, o, s1);
      ref_q = got_q;
      build_exp(m, v, t);
      n_chk++;
      if (ref_q != exp_q) begin
        n_fail++;
        $display("FAIL stall%0d_model got %0d beats want %0d", it,
                 ref_q.size(), exp_q.size());
      end
      run_frame(m, v, t, 30, 0, d, f, o, s1);
      n_chk++;
      if (d < FRAME_CYC) begin
        n_fail++;
        $display("FAIL stall%0d_done got %0d want >=%0d", it, d, FRAME_CYC);
      end
      n_chk++;
      if (got_q.size() != ref_q.size()) begin
        n_fail++;
        $display("FAIL stall%0d_beats got %0d want %0d", it,
                 got_q.size(), ref_q.size());
      end
      for (int j = 0; j < got_q.size() && j < ref_q.size(); j++) begin
        n_chk++;
        if (got_q[j] !== ref_q[j]) begin
          n_fail++;
          $display("FAIL stall%0d_beat%0d got %h want %h", it, j,
                   got_q[j], ref_q[j]);
        end
      end
      n_chk++;
      if (viol_stall !== 0 || viol_out !== 0 || addr_bad !== 0 ||
          rd_n !== acc_n || done_cnt !== 1) begin
        n_fail++;
        $display("FAIL stall%0d_protocol got hold=%0d over=%0d addr=%0d rd=%0d acc=%0d done=%0d want 0/0/0/eq/1",
                 it, viol_stall, viol_out, addr_bad, rd_n, acc_n, done_cnt);
      end
    end
  endtask

  task automatic test_reset_mid();
    int d, f, o;
    logic [1:0] s1;
    bit seen;
    for (int i = 0; i < NW; i++) ram[i] = {16'($urandom), $urandom};
    clear_mon();
    @(posedge HCLK); #1;
    start = 1;
    mode = 3'd2;
    value = 8'd40;
    @(posedge HCLK); #1;
    start = 0;
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge HCLK);
      if (mem_rd) seen = 1;
    end
    n_chk++;
    if (!seen) begin
      n_fail++;
      $display("FAIL midrst_wait got no read want read");
    end
    @(posedge HCLK);
    @(posedge HCLK); #2;
    HRESETn = 0;
    #1;
    n_chk++;
    if ({mem_rd, mem_addr, out_valid, out_data, sof, eol, eof,
         VSYNC, HSYNC, busy, ctrl_done} !== '0) begin
      n_fail++;
      $display("FAIL midrst_async got v=%b busy=%b data=%h want 0",
               out_valid, busy, out_data);
    end
    @(posedge HCLK);
    @(posedge HCLK); #1;
    HRESETn = 1;
    repeat (3) @(posedge HCLK);
    n_chk++;
    if (done_cnt !== 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_idle got done=%0d busy=%b want 0/0",
               done_cnt, busy);
    end
    run_frame(3, 0, 0, 0, 0, d, f, o, s1);
    build_exp(3, 0, 0);
    n_chk++;
    if (got_q != exp_q || d !== FRAME_CYC) begin
      n_fail++;
      $display("FAIL midrst_frame got beats=%0d cyc=%0d want %0d/%0d",
               got_q.size(), d, exp_q.size(), FRAME_CYC);
    end
    n_chk++;
    if (got_q.size() == 0 || got_q[0][DW+2] !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_sof got %0d beats want sof first",
               got_q.size());
    end
  endtask

  task automatic test_ignore();
    int d, f, o;
    logic [1:0] s1;
    for (int i = 0; i < NW; i++) ram[i] = {16'($urandom), $urandom};
    run_frame(1, 50, 0, 0, 1, d, f, o, s1);
    build_exp(1, 50, 0);
    n_chk++;
    if (got_q != exp_q) begin
      n_fail++;
      $display("FAIL ignore_frame got %0d beats want %0d matching",
               got_q.size(), exp_q.size());
    end
    n_chk++;
    if (d !== FRAME_CYC) begin
      n_fail++;
      $display("FAIL ignore_cycles got %0d want %0d", d, FRAME_CYC);
    end
    repeat (40) @(posedge HCLK);
    #1;
    n_chk++;
    if (busy !== 1'b0 || done_cnt !== 1) begin
      n_fail++;
      $display("FAIL ignore_restart got busy=%b done=%0d want 0/1",
               busy, done_cnt);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_order();
    test_ops();
    test_stall();
    test_reset_mid();
    test_ignore();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
